cycle_sequencer: RTL

//  CPU-side timing/sequencing front end feeding the instruction controller. Derives the
//  clk_ph1/clk_ph2 phase strobes from sys_clock, latches the data bus into the pre-decode

---
 rtl/cycle_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: CPU timing and sequencing front end for the instruction controller.
// It derives the clk_ph1/clk_ph2 phase strobes from sys_clock and latches the read bus
// into the pre-decode register PD. It also issues the I/R/S cycle-counter commands and
// arbitrates RESET/NMI/IRQ into int_flag/int_src, which force BRK at the next opcode fetch.
// Build option: define SEQ_INT_SYNC_EN to route nmi_n and irq_n through 2-flop
// synchronizers (2 sys_clock of extra latency). Leave it undefined when both inputs
// are already synchronous to sys_clock.
module cycle_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       sys_clock,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       rw,
  input  logic       rdy,
  input  logic       t_last,
  input  logic       t_skip,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic       clk_ph1,
  output logic       clk_ph2,
  output logic [7:0] PD,
  output logic       I_cycle,
  output logic       R_cycle,
  output logic       S_cycle,
  output logic       int_flag,
  output logic [1:0] int_src
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_IRQ   = 2'd1;
  localparam logic [1:0] SRC_NMI   = 2'd2;
  localparam logic [1:0] SRC_RESET = 2'd3;

  logic [CNT_W-1:0] div_cnt;
  logic             rdy_ok;
  logic             nmi_s;
  logic             irq_s;
  logic             nmi_prev;
  logic             nmi_pend;
  logic             nmi_edge;
  logic             nmi_taken;
  logic             arb_now;

`ifdef SEQ_INT_SYNC_EN
  logic nmi_p0, nmi_p1;
  logic irq_p0, irq_p1;

  // Two-flop synchronizers; idle-high so reset never looks like a request
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      nmi_p0 <= 1'b1;
      nmi_p1 <= 1'b1;
      irq_p0 <= 1'b1;
      irq_p1 <= 1'b1;
    end else begin
      nmi_p0 <= nmi_n;
      nmi_p1 <= nmi_p0;
      irq_p0 <= irq_n;
      irq_p1 <= irq_p0;
    end
  end

  assign nmi_s = nmi_p1;
  assign irq_s = irq_p1;
`else
  assign nmi_s = nmi_n;
  assign irq_s = irq_n;
`endif

  // RDY only stalls read cycles; writes always proceed
  assign rdy_ok = rdy | ~rw;

  // Arbitration point: mid-cycle of an instruction's final, non-stalled cycle
  assign arb_now = clk_ph2 & t_last & rdy_ok;

  // A falling NMI edge, and the tick the controller consumes a pending NMI
  assign nmi_edge  = nmi_prev & ~nmi_s;
  assign nmi_taken = clk_ph1 & R_cycle & (int_src == SRC_NMI);

  // Phase divider: ph1 registered at count 0, ph2 at the half-way count
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      clk_ph1 <= 1'b0;
      clk_ph2 <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
      clk_ph1 <= (div_cnt == '0);
      clk_ph2 <= (div_cnt == CNT_HALF);
    end
  end

  // Cycle-counter commands: one-hot when the cycle may proceed, all low on a stall
  always_comb begin
    I_cycle = 1'b0;
    R_cycle = 1'b0;
    S_cycle = 1'b0;
    if (rdy_ok) begin
      if (t_last)      R_cycle = 1'b1;
      else if (t_skip) S_cycle = 1'b1;
      else             I_cycle = 1'b1;
    end
  end

  // Pre-decode register: capture read data mid-cycle unless the cycle is stalled
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      PD <= 8'h00;
    end else if (clk_ph2 && rdy_ok) begin
      PD <= data_in;
    end
  end

  // NMI edge detector; a new edge wins over the clear on the IR-load tick
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      if (nmi_edge)       nmi_pend <= 1'b1;
      else if (nmi_taken) nmi_pend <= 1'b0;
    end
  end

  // Interrupt arbitration at instruction end; reset leaves RESET pending for the first one
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      int_flag <= 1'b1;
      int_src  <= SRC_RESET;
    end else if (arb_now) begin
      if (nmi_pend) begin
        int_flag <= 1'b1;
        int_src  <= SRC_NMI;
      end else if (!irq_s && !i_flag) begin
        int_flag <= 1'b1;
        int_src  <= SRC_IRQ;
      end else begin
        int_flag <= 1'b0;
        int_src  <= SRC_NONE;
      end
    end
  end

endmodule
